// File: rtl/cpu7_excp_ctrl.sv
// -----------------------------------------------------------------------------
// cpu7_excp_ctrl
//
// Exception / ERTN sequencer sitting between the commit stage and the CSR file.
// An exception is serialised into CSR writes: ERA <= faulting PC, PRMD <=
// {IE, PLV} taken from CRMD, CRMD <= 0, then fetch is redirected to EENTRY.
// ERTN restores CRMD from PRMD and redirects fetch to ERA. While idle, the
// pipeline's own CSR read/write port passes straight through to the CSR file.
//
// Optional feature macro: CPU7_EXCP_ESTAT_EN
//   defined   -> an extra WR_ESTAT step writes Ecode into ESTAT[21:16] after
//                CRMD is cleared; the exception redirect moves one cycle later.
//   undefined -> no ESTAT step, excp_ecode is not used.
//
// GRLEN and the LSOC1K_CSR_* address macros normally come from common.vh; the
// defaults below apply when that header has not been pulled in.
//
// Ports:
//   clk, resetn                      core clock, async active-low reset
//   excp_valid/excp_ecode/excp_pc    exception request (held until excp_ack)
//   ertn_valid                       ERTN request (held until excp_ack)
//   excp_ack                         request accepted (combinational, IDLE only)
//   excp_busy                        sequence in progress, pipeline stalls
//   redirect_valid/redirect_pc       one-cycle fetch redirect
//   pipe_csr_*                       pipeline CSR port (pass-through in IDLE)
//   csr_raddr/waddr/wdata/wen        to CSR file
//   csr_rdata, csr_eentry            from CSR file
//
// States:
//   IDLE      | pipe port passes through, requests accepted
//   SAVE_ERA  | write ERA = captured PC, read CRMD and keep IE/PLV
//   SAVE_PRMD | write PRMD = {IE, PLV}
//   SET_CRMD  | write CRMD = 0
//   WR_ESTAT  | write ESTAT.Ecode (only with CPU7_EXCP_ESTAT_EN)
//   RET_CRMD  | read PRMD and write CRMD = {PIE, PPLV} in the same cycle
//   RET_ERA   | read ERA as the return target
//   REDIRECT  | one-cycle redirect pulse, then back to IDLE
// -----------------------------------------------------------------------------
`ifndef GRLEN
`define GRLEN 32
`endif
`ifndef LSOC1K_CSR_BIT
`define LSOC1K_CSR_BIT 14
`endif
`ifndef LSOC1K_CSR_CRMD
`define LSOC1K_CSR_CRMD 'h000
`endif
`ifndef LSOC1K_CSR_PRMD
`define LSOC1K_CSR_PRMD 'h001
`endif
`ifndef LSOC1K_CSR_ESTAT
`define LSOC1K_CSR_ESTAT 'h005
`endif
`ifndef LSOC1K_CSR_ERA
`define LSOC1K_CSR_ERA 'h006
`endif

module cpu7_excp_ctrl (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       excp_valid,
  input  logic [5:0]                 excp_ecode,
  input  logic [`GRLEN-1:0]          excp_pc,
  input  logic                       ertn_valid,
  output logic                       excp_ack,
  output logic                       excp_busy,
  output logic                       redirect_valid,
  output logic [`GRLEN-1:0]          redirect_pc,
  input  logic [`LSOC1K_CSR_BIT-1:0] pipe_csr_raddr,
  input  logic [`LSOC1K_CSR_BIT-1:0] pipe_csr_waddr,
  input  logic [`GRLEN-1:0]          pipe_csr_wdata,
  input  logic                       pipe_csr_wen,
  output logic [`GRLEN-1:0]          pipe_csr_rdata,
  output logic [`LSOC1K_CSR_BIT-1:0] csr_raddr,
  output logic [`LSOC1K_CSR_BIT-1:0] csr_waddr,
  output logic [`GRLEN-1:0]          csr_wdata,
  output logic                       csr_wen,
  input  logic [`GRLEN-1:0]          csr_rdata,
  input  logic [`GRLEN-1:0]          csr_eentry
);

  localparam logic [`LSOC1K_CSR_BIT-1:0] ADDR_CRMD  = `LSOC1K_CSR_BIT'(`LSOC1K_CSR_CRMD);
  localparam logic [`LSOC1K_CSR_BIT-1:0] ADDR_PRMD  = `LSOC1K_CSR_BIT'(`LSOC1K_CSR_PRMD);
  localparam logic [`LSOC1K_CSR_BIT-1:0] ADDR_ERA   = `LSOC1K_CSR_BIT'(`LSOC1K_CSR_ERA);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SAVE_ERA  = 3'd1,
    SAVE_PRMD = 3'd2,
    SET_CRMD  = 3'd3,
    RET_CRMD  = 3'd4,
    RET_ERA   = 3'd5,
    REDIRECT  = 3'd6
`ifdef CPU7_EXCP_ESTAT_EN
    , WR_ESTAT = 3'd7
`endif
  } state_t;

  state_t            state_q;
  logic [`GRLEN-1:0] pc_q;
  logic [`GRLEN-1:0] target_q;
  logic              ie_q;
  logic [1:0]        plv_q;
  logic              is_excp_q;   // selects EENTRY (exception) or ERA (ERTN) at redirect

`ifdef CPU7_EXCP_ESTAT_EN
  localparam logic [`LSOC1K_CSR_BIT-1:0] ADDR_ESTAT = `LSOC1K_CSR_BIT'(`LSOC1K_CSR_ESTAT);
  logic [5:0] ecode_q;
`else
  logic unused_ecode;
  assign unused_ecode = ^excp_ecode;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      target_q  <= '0;
      ie_q      <= 1'b0;
      plv_q     <= 2'b00;
      is_excp_q <= 1'b0;
`ifdef CPU7_EXCP_ESTAT_EN
      ecode_q   <= 6'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // exception has priority; a simultaneous ERTN stays pending
          if (excp_valid) begin
            state_q   <= SAVE_ERA;
            pc_q      <= excp_pc;
            is_excp_q <= 1'b1;
`ifdef CPU7_EXCP_ESTAT_EN
            ecode_q   <= excp_ecode;
`endif
          end else if (ertn_valid) begin
            state_q   <= RET_CRMD;
            is_excp_q <= 1'b0;
          end
        end
        SAVE_ERA: begin
          ie_q    <= csr_rdata[2];
          plv_q   <= csr_rdata[1:0];
          state_q <= SAVE_PRMD;
        end
        SAVE_PRMD: state_q <= SET_CRMD;
`ifdef CPU7_EXCP_ESTAT_EN
        SET_CRMD:  state_q <= WR_ESTAT;
        WR_ESTAT:  state_q <= REDIRECT;
`else
        SET_CRMD:  state_q <= REDIRECT;
`endif
        RET_CRMD:  state_q <= RET_ERA;
        RET_ERA: begin
          target_q <= csr_rdata;
          state_q  <= REDIRECT;
        end
        REDIRECT:  state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    excp_ack       = 1'b0;
    excp_busy      = (state_q != IDLE);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pipe_csr_rdata = '0;
    csr_raddr      = pipe_csr_raddr;
    csr_waddr      = pipe_csr_waddr;
    csr_wdata      = pipe_csr_wdata;
    csr_wen        = 1'b0;
    case (state_q)
      IDLE: begin
        excp_ack       = excp_valid | ertn_valid;
        csr_wen        = pipe_csr_wen;
        pipe_csr_rdata = csr_rdata;
      end
      SAVE_ERA: begin
        csr_raddr = ADDR_CRMD;
        csr_waddr = ADDR_ERA;
        csr_wdata = pc_q;
        csr_wen   = 1'b1;
      end
      SAVE_PRMD: begin
        csr_waddr = ADDR_PRMD;
        csr_wdata = {{(`GRLEN-3){1'b0}}, ie_q, plv_q};
        csr_wen   = 1'b1;
      end
      SET_CRMD: begin
        csr_waddr = ADDR_CRMD;
        csr_wdata = '0;
        csr_wen   = 1'b1;
      end
`ifdef CPU7_EXCP_ESTAT_EN
      WR_ESTAT: begin
        csr_waddr = ADDR_ESTAT;
        csr_wdata = {{(`GRLEN-22){1'b0}}, ecode_q, 16'b0};
        csr_wen   = 1'b1;
      end
`endif
      RET_CRMD: begin
        // PRMD read data feeds the CRMD write in the same cycle
        csr_raddr = ADDR_PRMD;
        csr_waddr = ADDR_CRMD;
        csr_wdata = {{(`GRLEN-3){1'b0}}, csr_rdata[2:0]};
        csr_wen   = 1'b1;
      end
      RET_ERA: begin
        csr_raddr = ADDR_ERA;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = is_excp_q ? csr_eentry : target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu7_excp_ctrl.sv
`ifndef GRLEN
`define GRLEN 32
`endif
`ifndef LSOC1K_CSR_BIT
`define LSOC1K_CSR_BIT 14
`endif

module tb_cpu7_excp_ctrl;

  localparam int A_CRMD = 0, A_PRMD = 1, A_ESTAT = 5, A_ERA = 6, A_EENTRY = 12;
`ifdef CPU7_EXCP_ESTAT_EN
  localparam int EXC_LAT = 5;
`else
  localparam int EXC_LAT = 4;
`endif
  localparam int RET_LAT = 3;

  logic                       clk = 1'b0;
  logic                       resetn;
  logic                       excp_valid, ertn_valid;
  logic [5:0]                 excp_ecode;
  logic [`GRLEN-1:0]          excp_pc;
  logic                       excp_ack, excp_busy, redirect_valid;
  logic [`GRLEN-1:0]          redirect_pc;
  logic [`LSOC1K_CSR_BIT-1:0] pipe_csr_raddr, pipe_csr_waddr;
  logic [`GRLEN-1:0]          pipe_csr_wdata, pipe_csr_rdata;
  logic                       pipe_csr_wen;
  logic [`LSOC1K_CSR_BIT-1:0] csr_raddr, csr_waddr;
  logic [`GRLEN-1:0]          csr_wdata, csr_rdata, csr_eentry;
  logic                       csr_wen;

  always #5 clk = ~clk;

  cpu7_excp_ctrl dut (
    .clk(clk), .resetn(resetn),
    .excp_valid(excp_valid), .excp_ecode(excp_ecode), .excp_pc(excp_pc),
    .ertn_valid(ertn_valid), .excp_ack(excp_ack), .excp_busy(excp_busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pipe_csr_raddr(pipe_csr_raddr), .pipe_csr_waddr(pipe_csr_waddr),
    .pipe_csr_wdata(pipe_csr_wdata), .pipe_csr_wen(pipe_csr_wen),
    .pipe_csr_rdata(pipe_csr_rdata),
    .csr_raddr(csr_raddr), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_wen(csr_wen), .csr_rdata(csr_rdata), .csr_eentry(csr_eentry)
  );

  // ---------------- CSR file model (environment) ----------------
  logic [31:0] csr_mem [16];
  logic        w_pend, pre_pend;
  logic [3:0]  w_addr, pre_addr;
  logic [31:0] w_data, pre_data;

  assign csr_rdata  = (csr_raddr < 16) ? csr_mem[csr_raddr[3:0]] : '0;
  assign csr_eentry = csr_mem[A_EENTRY];

  always @(negedge clk) begin
    w_pend = csr_wen && (csr_waddr < 16);
    w_addr = csr_waddr[3:0];
    w_data = csr_wdata;
  end
  always @(posedge clk) begin
    if (w_pend === 1'b1) csr_mem[w_addr] <= w_data;
    if (pre_pend === 1'b1) csr_mem[pre_addr] <= pre_data;
  end

  // ---------------- reference: architectural CSR contents ----------------
  logic [31:0] ref_mem [16];
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 16; i++)
      if (csr_mem[i] !== ref_mem[i]) begin
        bad++;
        $display("  csr[%0d] dut-side 0x%08h model 0x%08h", i, csr_mem[i], ref_mem[i]);
      end
    chk(name, bad, 0);
  endtask

  task automatic preset(input int addr, input logic [31:0] data);
    pre_addr = 4'(addr);
    pre_data = data;
    pre_pend = 1'b1;
    @(posedge clk); #1;
    pre_pend = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic drive_pipe(input bit noise);
    pipe_csr_raddr = `LSOC1K_CSR_BIT'($urandom_range(0, 15));
    pipe_csr_waddr = `LSOC1K_CSR_BIT'($urandom_range(0, 15));
    pipe_csr_wdata = $urandom;
    pipe_csr_wen   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_pipe(1'b1);
      @(negedge clk);
      chk("idle_busy", excp_busy, 0);
      chk("idle_redirect", redirect_valid, 0);
      chk("idle_rdata", pipe_csr_rdata, ref_mem[pipe_csr_raddr[3:0]]);
      chk("idle_wen_pass", csr_wen, pipe_csr_wen);
      if (pipe_csr_wen) ref_mem[pipe_csr_waddr[3:0]] = pipe_csr_wdata;
      @(posedge clk); #1;
    end
  endtask

  // One request from the first cycle it is presented to the first IDLE cycle after it.
  task automatic do_req(input bit ertn, input bit both, input logic [31:0] pc,
                        input logic [5:0] ec, input bit noise, input int inj_k);
    logic [31:0] exp_pc;
    logic [35:0] wq[$];
    logic [35:0] w;
    int          lat;
    bit          seen = 0;
    bit          is_exc = !ertn || both;
    excp_valid = is_exc;
    ertn_valid = ertn || both;
    excp_pc    = pc;
    excp_ecode = ec;
    drive_pipe(noise);
    @(negedge clk);
    chk("ack", excp_ack, 1);
    chk("accept_busy", excp_busy, 0);
    chk("accept_rdata", pipe_csr_rdata, ref_mem[pipe_csr_raddr[3:0]]);
    chk("accept_wen_pass", csr_wen, pipe_csr_wen);
    // a write in the accept cycle belongs to an older instruction
    if (pipe_csr_wen) ref_mem[pipe_csr_waddr[3:0]] = pipe_csr_wdata;
    if (is_exc) begin
      wq.push_back({4'(A_ERA), pc});
      wq.push_back({4'(A_PRMD), 32'(ref_mem[A_CRMD][2:0])});
      wq.push_back({4'(A_CRMD), 32'h0});
      ref_mem[A_PRMD] = 32'(ref_mem[A_CRMD][2:0]);
      ref_mem[A_ERA]  = pc;
      ref_mem[A_CRMD] = 32'h0;
`ifdef CPU7_EXCP_ESTAT_EN
      wq.push_back({4'(A_ESTAT), 32'(ec) << 16});
      ref_mem[A_ESTAT] = 32'(ec) << 16;
`endif
      exp_pc = ref_mem[A_EENTRY];
      lat    = EXC_LAT;
    end else begin
      wq.push_back({4'(A_CRMD), 32'(ref_mem[A_PRMD][2:0])});
      ref_mem[A_CRMD] = 32'(ref_mem[A_PRMD][2:0]);
      exp_pc = ref_mem[A_ERA];
      lat    = RET_LAT;
    end
    @(posedge clk); #1;
    excp_valid = 1'b0;
    if (!both) ertn_valid = 1'b0;
    for (int k = 1; k <= lat + 3; k++) begin
      drive_pipe(noise);
      if (k == inj_k) begin
        pipe_csr_wen   = 1'b1;
        pipe_csr_waddr = `LSOC1K_CSR_BIT'(A_EENTRY);
        pipe_csr_wdata = 32'h0000_2000;
      end
      @(negedge clk);
      chk("seq_busy", excp_busy, 1);
      chk("seq_ack", excp_ack, 0);
      chk("seq_rdata_zero", pipe_csr_rdata, 0);
      if (redirect_valid) begin
        chk("redirect_cycle", k, lat);
        chk("redirect_pc", redirect_pc, exp_pc);
        chk("redirect_wen", csr_wen, 0);
        seen = 1;
        break;
      end
      if (csr_wen) begin
        if (wq.size() == 0) chk("extra_write", 1, 0);
        else begin
          w = wq.pop_front();
          chk("write_addr", 32'(csr_waddr), 32'(w[35:32]));
          chk("write_data", csr_wdata, w[31:0]);
        end
      end
      @(posedge clk); #1;
    end
    if (!seen) chk("redirect_seen", 0, 1);
    chk("writes_missing", wq.size(), 0);
    chk_mem("csr_state");
    @(posedge clk); #1;
    pipe_csr_wen = 1'b0;
    if (!ertn_valid) begin
      @(negedge clk);
      chk("busy_after", excp_busy, 0);
      chk("redirect_pulse_len", redirect_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    bit          ertn;
    bit          pre;
    logic [31:0] crmd, eentry, pc;
    logic [5:0]  ec;
    logic [31:0] exp_rpc, exp_era, exp_prmd, exp_crmd;
  } vec_t;

  vec_t vt [5];

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; excp_valid = 1'b0; ertn_valid = 1'b0;
    excp_ecode = '0; excp_pc = '0; pre_pend = 1'b0;
    pipe_csr_raddr = '0; pipe_csr_waddr = '0; pipe_csr_wdata = '0; pipe_csr_wen = 1'b0;

    vt[0] = '{0, 1, 32'h7, 32'h1C000100, 32'h1C000040, 6'h0B, 32'h1C000100, 32'h1C000040, 32'h7, 32'h0};
    vt[1] = '{1, 0, 32'h0, 32'h0,        32'h0,        6'h00, 32'h1C000040, 32'h1C000040, 32'h7, 32'h7};
    vt[2] = '{0, 1, 32'h5, 32'h1C000800, 32'h1C000200, 6'h01, 32'h1C000800, 32'h1C000200, 32'h5, 32'h0};
    vt[3] = '{1, 0, 32'h0, 32'h0,        32'h0,        6'h00, 32'h1C000200, 32'h1C000200, 32'h5, 32'h5};
    vt[4] = '{0, 1, 32'h0, 32'h1C000100, 32'hFFFFFFFC, 6'h3F, 32'h1C000100, 32'hFFFFFFFC, 32'h0, 32'h0};

    for (int i = 0; i < 16; i++) preset(i, 32'h0);
    @(negedge clk);
    chk("rst_busy", excp_busy, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_csr_wen", csr_wen, 0);
    chk("rst_ack", excp_ack, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // directed table
    for (int i = 0; i < 5; i++) begin
      if (vt[i].pre) begin
        preset(A_CRMD, vt[i].crmd);
        preset(A_EENTRY, vt[i].eentry);
      end
      do_req(vt[i].ertn, 0, vt[i].pc, vt[i].ec, 0, 0);
      chk("tbl_era", csr_mem[A_ERA], vt[i].exp_era);
      chk("tbl_prmd", csr_mem[A_PRMD], vt[i].exp_prmd);
      chk("tbl_crmd", csr_mem[A_CRMD], vt[i].exp_crmd);
`ifdef CPU7_EXCP_ESTAT_EN
      if (!vt[i].ertn) chk("tbl_estat", csr_mem[A_ESTAT], {10'b0, vt[i].ec, 16'b0});
`endif
    end

    // simultaneous requests: exception first, ERTN acked in first IDLE cycle after
    preset(A_CRMD, 32'h6);
    do_req(0, 1, 32'h1C000300, 6'h04, 0, 0);
    do_req(1, 0, 32'h0, 6'h0, 0, 0);
    chk("both_crmd", csr_mem[A_CRMD], 32'h6);

    // pipe write to EENTRY during SAVE_PRMD must be dropped
    preset(A_EENTRY, 32'h1C000100);
    preset(A_CRMD, 32'h7);
    do_req(0, 0, 32'h1C000400, 6'h08, 0, 2);
    chk("eentry_kept", csr_mem[A_EENTRY], 32'h1C000100);

    // reset dropped at SAVE_PRMD
    preset(A_CRMD, 32'h7);
    preset(A_PRMD, 32'h3);
    excp_valid = 1'b1; excp_pc = 32'h1C000500; excp_ecode = 6'h02;
    @(negedge clk);
    chk("rstseq_ack", excp_ack, 1);
    ref_mem[A_ERA] = 32'h1C000500;
    @(posedge clk); #1;
    excp_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstseq_busy_pre", excp_busy, 1);
    chk("rstseq_wen_pre", csr_wen, 1);
    resetn = 1'b0;
    #1;
    chk("rstseq_busy", excp_busy, 0);
    chk("rstseq_redirect", redirect_valid, 0);
    chk("rstseq_redirect_pc", redirect_pc, 0);
    chk("rstseq_wen", csr_wen, 0);
    @(posedge clk);
    @(negedge clk);
    chk_mem("rstseq_csr_state");
    chk("rstseq_prmd", csr_mem[A_PRMD], 32'h3);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    do_req(0, 0, 32'h1C000600, 6'h0B, 0, 0);
    chk("rstseq_next_prmd", csr_mem[A_PRMD], 32'h7);

    // randomized traffic against the reference model
    for (int it = 0; it < 30; it++) begin
      int sel;
      idle_cycles($urandom_range(0, 3));
      sel = $urandom_range(0, 19);
      if (sel < 10)
        do_req(0, 0, $urandom & 32'hFFFF_FFFC, 6'($urandom), 1, 0);
      else if (sel < 17)
        do_req(1, 0, 32'h0, 6'h0, 1, 0);
      else begin
        do_req(0, 1, $urandom & 32'hFFFF_FFFC, 6'($urandom), 1, 0);
        do_req(1, 0, 32'h0, 6'h0, 1, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
